// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Stall vector bit order is {wb,mem,ex,id,if,pc}.
package pipe_ctrl_pkg;

   typedef logic [5:0] stall_bus_t;

   localparam stall_bus_t StallNone    = 6'b000000;
   localparam stall_bus_t StallLoadUse = 6'b000111;
   localparam stall_bus_t StallMc      = 6'b001111;

   localparam int MC_TIMEOUT = 64;
   localparam int WAIT_W     = 7;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/EX hazard inputs and stall/flush/multi-cycle outputs.
// master drives the pipeline side, slave is the controller.
interface pipe_ctrl_if;
   logic        id_reg1_read_i;
   logic        id_reg2_read_i;
   logic [4:0]  id_reg1_addr_i;
   logic [4:0]  id_reg2_addr_i;
   logic        ex_is_load_i;
   logic        ex_wreg_i;
   logic [4:0]  ex_wd_i;
   logic        ex_mc_req_i;
   logic        mc_done_i;
   logic        branch_flush_i;
   logic [31:0] branch_target_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        mc_start_o;
   logic        mc_abort_o;
   logic        mc_err_o;
   logic [15:0] stall_cnt_o;

   modport master (
      output id_reg1_read_i, id_reg2_read_i,
      output id_reg1_addr_i, id_reg2_addr_i,
      output ex_is_load_i, ex_wreg_i, ex_wd_i,
      output ex_mc_req_i, mc_done_i,
      output branch_flush_i, branch_target_i,
      input  stall_o, flush_o, new_pc_o,
      input  mc_start_o, mc_abort_o,
      input  mc_err_o, stall_cnt_o
   );

   modport slave (
      input  id_reg1_read_i, id_reg2_read_i,
      input  id_reg1_addr_i, id_reg2_addr_i,
      input  ex_is_load_i, ex_wreg_i, ex_wd_i,
      input  ex_mc_req_i, mc_done_i,
      input  branch_flush_i, branch_target_i,
      output stall_o, flush_o, new_pc_o,
      output mc_start_o, mc_abort_o,
      output mc_err_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard: EX load writes a non-zero rd
// that the decode stage is about to read.
module hazard_det (
   input  logic       reg1_read,
   input  logic       reg2_read,
   input  logic [4:0] reg1_addr,
   input  logic [4:0] reg2_addr,
   input  logic       ex_is_load,
   input  logic       ex_wreg,
   input  logic [4:0] ex_wd,
   output logic       hazard
);

   logic hit1;
   logic hit2;

   assign hit1 = reg1_read & (reg1_addr == ex_wd);
   assign hit2 = reg2_read & (reg2_addr == ex_wd);

   assign hazard = ex_is_load & ex_wreg
                 & (ex_wd != 5'd0)
                 & (hit1 | hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with multi-cycle
// unit handshake, wait timeout and stall-cycle counter.
import pipe_ctrl_pkg::*;

module pipe_ctrl (
   input  logic    clk,
   input  logic    rst,
   pipe_ctrl_if.slave bus
);

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [15:0]         stall_cnt;
   logic                mc_err;

   logic                hazard;
   logic                timeout;
   stall_bus_t          stall;
   logic                flush;
   logic [31:0]         new_pc;
   logic                start;
   logic                abort;

   hazard_det u_hazard (
      .reg1_read  (bus.id_reg1_read_i),
      .reg2_read  (bus.id_reg2_read_i),
      .reg1_addr  (bus.id_reg1_addr_i),
      .reg2_addr  (bus.id_reg2_addr_i),
      .ex_is_load (bus.ex_is_load_i),
      .ex_wreg    (bus.ex_wreg_i),
      .ex_wd      (bus.ex_wd_i),
      .hazard     (hazard)
   );

   assign timeout = (wait_cnt == WAIT_W'(MC_TIMEOUT - 1));

   // all pulses are forced low while reset is held
   always_comb begin
      stall  = StallNone;
      flush  = 1'b0;
      new_pc = 32'd0;
      start  = 1'b0;
      abort  = 1'b0;
      if (rst) begin
         unique case (state)
            RUN: begin
               if (bus.branch_flush_i) begin
                  flush  = 1'b1;
                  new_pc = bus.branch_target_i;
               end else if (bus.ex_mc_req_i) begin
                  start = 1'b1;
                  stall = StallMc;
               end else if (hazard) begin
                  stall = StallLoadUse;
               end
            end
            MC_WAIT: begin
               if (bus.mc_done_i) begin
                  stall = StallNone;
               end else if (timeout) begin
                  abort = 1'b1;
               end else begin
                  stall = StallMc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= 16'd0;
         mc_err    <= 1'b0;
      end else begin
         if (stall[0] && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         unique case (state)
            RUN: begin
               if (start) begin
                  state    <= MC_WAIT;
                  wait_cnt <= '0;
               end
            end
            MC_WAIT: begin
               if (bus.mc_done_i) begin
                  state <= RUN;
               end else if (timeout) begin
                  state  <= RUN;
                  mc_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
         endcase
      end
   end

   assign bus.stall_o     = stall;
   assign bus.flush_o     = flush;
   assign bus.new_pc_o    = new_pc;
   assign bus.mc_start_o  = start;
   assign bus.mc_abort_o  = abort;
   assign bus.mc_err_o    = mc_err;
   assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector table plus multi-cycle sequences
// for the pipeline stall/flush controller.
module tb_pipe_ctrl;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pipe_ctrl_if bus ();

   pipe_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r1rd;
      logic [4:0]  r1a;
      logic        r2rd;
      logic [4:0]  r2a;
      logic        ld;
      logic        wr;
      logic [4:0]  wd;
      logic        mcq;
      logic        done;
      logic        bf;
      logic [31:0] tgt;
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
      logic        e_start;
   } vec_t;

   vec_t tv[12];

   function automatic vec_t mk(
      input logic r1rd, input logic [4:0] r1a,
      input logic r2rd, input logic [4:0] r2a,
      input logic ld, input logic wr,
      input logic [4:0] wd, input logic mcq,
      input logic done, input logic bf,
      input logic [31:0] tgt, input logic [5:0] es,
      input logic ef, input logic [31:0] ep,
      input logic est);
      vec_t v;
      v.r1rd = r1rd; v.r1a = r1a;
      v.r2rd = r2rd; v.r2a = r2a;
      v.ld = ld; v.wr = wr; v.wd = wd;
      v.mcq = mcq; v.done = done;
      v.bf = bf; v.tgt = tgt;
      v.e_stall = es; v.e_flush = ef;
      v.e_pc = ep; v.e_start = est;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
      end
   endtask

   task automatic clr();
      bus.id_reg1_read_i  = 1'b0;
      bus.id_reg2_read_i  = 1'b0;
      bus.id_reg1_addr_i  = 5'd0;
      bus.id_reg2_addr_i  = 5'd0;
      bus.ex_is_load_i    = 1'b0;
      bus.ex_wreg_i       = 1'b0;
      bus.ex_wd_i         = 5'd0;
      bus.ex_mc_req_i     = 1'b0;
      bus.mc_done_i       = 1'b0;
      bus.branch_flush_i  = 1'b0;
      bus.branch_target_i = 32'd0;
   endtask

   task automatic load_use(input logic [4:0] r);
      bus.id_reg1_read_i = 1'b1;
      bus.id_reg1_addr_i = r;
      bus.ex_is_load_i   = 1'b1;
      bus.ex_wreg_i      = 1'b1;
      bus.ex_wd_i        = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr();
      rst = 1'b0;
      #2;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int exp_cnt;
      int errs;
      total = 0;
      bad   = 0;
      clr();
      rst = 1'b0;

      tv[0]  = mk(0,0,0,0, 0,0,0, 0,0,0,0,
                  6'b000000,0,0,0);
      tv[1]  = mk(1,5,0,0, 1,1,5, 0,0,0,0,
                  6'b000111,0,0,0);
      tv[2]  = mk(0,0,1,5, 1,1,5, 0,0,0,0,
                  6'b000111,0,0,0);
      tv[3]  = mk(0,5,0,5, 1,1,5, 0,0,0,0,
                  6'b000000,0,0,0);
      tv[4]  = mk(1,0,1,0, 1,1,0, 0,0,0,0,
                  6'b000000,0,0,0);
      tv[5]  = mk(1,5,0,0, 0,1,5, 0,0,0,0,
                  6'b000000,0,0,0);
      tv[6]  = mk(1,5,0,0, 1,0,5, 0,0,0,0,
                  6'b000000,0,0,0);
      tv[7]  = mk(1,6,1,7, 1,1,5, 0,0,0,0,
                  6'b000000,0,0,0);
      tv[8]  = mk(1,5,0,0, 1,1,5, 0,0,1,32'h44,
                  6'b000000,1,32'h44,0);
      tv[9]  = mk(0,0,0,0, 0,0,0, 1,0,1,32'h80,
                  6'b000000,1,32'h80,0);
      tv[10] = mk(0,0,0,0, 0,0,0, 0,1,0,0,
                  6'b000000,0,0,0);
      tv[11] = mk(0,0,1,31, 1,1,31, 0,0,0,0,
                  6'b000111,0,0,0);

      // reset: outputs low even with a hazard present
      #3;
      load_use(5'd5);
      bus.branch_flush_i  = 1'b1;
      bus.branch_target_i = 32'h1234;
      #1;
      chk("rst_stall", 32'(bus.stall_o), 0);
      chk("rst_flush", 32'(bus.flush_o), 0);
      chk("rst_pc", bus.new_pc_o, 0);
      chk("rst_cnt", 32'(bus.stall_cnt_o), 0);
      chk("rst_err", 32'(bus.mc_err_o), 0);
      @(negedge clk);
      clr();
      rst = 1'b1;

      exp_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.id_reg1_read_i  = tv[i].r1rd;
         bus.id_reg1_addr_i  = tv[i].r1a;
         bus.id_reg2_read_i  = tv[i].r2rd;
         bus.id_reg2_addr_i  = tv[i].r2a;
         bus.ex_is_load_i    = tv[i].ld;
         bus.ex_wreg_i       = tv[i].wr;
         bus.ex_wd_i         = tv[i].wd;
         bus.ex_mc_req_i     = tv[i].mcq;
         bus.mc_done_i       = tv[i].done;
         bus.branch_flush_i  = tv[i].bf;
         bus.branch_target_i = tv[i].tgt;
         #2;
         chk($sformatf("v%0d_stall", i),
             32'(bus.stall_o), 32'(tv[i].e_stall));
         chk($sformatf("v%0d_flush", i),
             32'(bus.flush_o), 32'(tv[i].e_flush));
         chk($sformatf("v%0d_pc", i),
             bus.new_pc_o, tv[i].e_pc);
         chk($sformatf("v%0d_start", i),
             32'(bus.mc_start_o), 32'(tv[i].e_start));
         if (tv[i].e_stall[0]) exp_cnt++;
      end
      @(negedge clk);
      clr();
      #2;
      chk("tbl_cnt", 32'(bus.stall_cnt_o), 32'(exp_cnt));

      // load-use stalls exactly one cycle, bubble follows
      @(negedge clk);
      load_use(5'd5);
      #2;
      chk("lu_stall", 32'(bus.stall_o), 32'h07);
      @(negedge clk);
      bus.ex_is_load_i = 1'b0;
      bus.ex_wreg_i    = 1'b0;
      bus.ex_wd_i      = 5'd0;
      #2;
      chk("lu_bubble", 32'(bus.stall_o), 0);

      // multi-cycle op done after 10 wait cycles
      do_reset();
      bus.ex_mc_req_i = 1'b1;
      #2;
      chk("mc_start", 32'(bus.mc_start_o), 1);
      chk("mc_st0", 32'(bus.stall_o), 32'h0F);
      errs = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 5) begin
            bus.branch_flush_i  = 1'b1;
            bus.branch_target_i = 32'h200;
            load_use(5'd3);
         end else begin
            bus.branch_flush_i = 1'b0;
            bus.ex_is_load_i   = 1'b0;
         end
         #2;
         if (k == 5) chk("mc_ign_bf", 32'(bus.flush_o), 0);
         if (bus.stall_o !== StallMc_c()) errs++;
         if (bus.mc_start_o !== 1'b0) errs++;
         if (bus.mc_abort_o !== 1'b0) errs++;
      end
      chk("mc_wait_errs", 32'(errs), 0);
      @(negedge clk);
      clr();
      bus.ex_mc_req_i = 1'b1;
      bus.mc_done_i   = 1'b1;
      #2;
      chk("mc_done_st", 32'(bus.stall_o), 0);
      chk("mc_done_ab", 32'(bus.mc_abort_o), 0);
      @(negedge clk);
      clr();
      load_use(5'd9);
      #2;
      chk("mc_cnt", 32'(bus.stall_cnt_o), 11);
      chk("mc_err0", 32'(bus.mc_err_o), 0);
      chk("mc_run", 32'(bus.stall_o), 32'h07);

      // no done: abort on the 64th wait cycle
      do_reset();
      bus.ex_mc_req_i = 1'b1;
      #2;
      chk("to_start", 32'(bus.mc_start_o), 1);
      errs = 0;
      for (int k = 1; k <= 63; k++) begin
         @(negedge clk);
         #2;
         if (bus.stall_o !== StallMc_c()) errs++;
         if (bus.mc_abort_o !== 1'b0) errs++;
      end
      chk("to_wait_errs", 32'(errs), 0);
      @(negedge clk);
      #2;
      chk("to_abort", 32'(bus.mc_abort_o), 1);
      chk("to_stall", 32'(bus.stall_o), 0);
      @(negedge clk);
      clr();
      load_use(5'd4);
      #2;
      chk("to_err", 32'(bus.mc_err_o), 1);
      chk("to_abort1", 32'(bus.mc_abort_o), 0);
      chk("to_cnt", 32'(bus.stall_cnt_o), 64);
      chk("to_run", 32'(bus.stall_o), 32'h07);

      // done coincident with timeout wins
      do_reset();
      chk("dt_err_clr", 32'(bus.mc_err_o), 0);
      bus.ex_mc_req_i = 1'b1;
      for (int k = 1; k <= 63; k++) @(negedge clk);
      @(negedge clk);
      bus.mc_done_i = 1'b1;
      #2;
      chk("dt_abort", 32'(bus.mc_abort_o), 0);
      chk("dt_stall", 32'(bus.stall_o), 0);
      @(negedge clk);
      clr();
      #2;
      chk("dt_err", 32'(bus.mc_err_o), 0);

      // reset in the middle of a wait
      do_reset();
      bus.ex_mc_req_i = 1'b1;
      for (int k = 1; k <= 4; k++) @(negedge clk);
      #2;
      chk("rw_pre", 32'(bus.stall_o), 32'h0F);
      bus.branch_flush_i  = 1'b1;
      bus.branch_target_i = 32'h80;
      rst = 1'b0;
      #1;
      chk("rw_stall", 32'(bus.stall_o), 0);
      chk("rw_abort", 32'(bus.mc_abort_o), 0);
      chk("rw_start", 32'(bus.mc_start_o), 0);
      chk("rw_flush", 32'(bus.flush_o), 0);
      chk("rw_pc", bus.new_pc_o, 0);
      chk("rw_cnt", 32'(bus.stall_cnt_o), 0);
      @(negedge clk);
      clr();
      rst = 1'b1;
      load_use(5'd7);
      #2;
      chk("rw_run", 32'(bus.stall_o), 32'h07);
      chk("rw_noab", 32'(bus.mc_abort_o), 0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   function automatic logic [5:0] StallMc_c();
      return 6'b001111;
   endfunction

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  pipeline clock, rising edge.
REQ-003 rst  in  1  asynchronous reset, active-low.
REQ-004 id_reg1_read_i, id_reg2_read_i  in  1 each  decode-stage source-read enables.
REQ-005 id_reg1_addr_i, id_reg2_addr_i  in  5 each  decode-stage rs1/rs2 addresses.
REQ-006 ex_is_load_i, ex_wreg_i  in  1 each  EX-stage op is a load / writes rd.
REQ-007 ex_wd_i  in  5  EX-stage rd.
REQ-008 ex_mc_req_i  in  1  EX-stage op needs the multi-cycle unit (mul/div).
REQ-009 mc_done_i  in  1  multi-cycle unit result valid, one-cycle pulse.
REQ-010 branch_flush_i  in  1  EX resolved a taken branch or jump.
REQ-011 branch_target_i  in  32  redirect PC.
REQ-012 stall_o  out  6  hold vector {wb,mem,ex,id,if,pc}; bit 1 holds that stage.
REQ-013 flush_o  out  1  kill IF/ID contents.
REQ-014 new_pc_o  out  32  redirect PC, valid while flush_o=1.
REQ-015 mc_start_o, mc_abort_o  out  1 each  one-cycle start and abort pulses to the multi-cycle unit.
REQ-016 mc_err_o  out  1  sticky timeout flag.
REQ-017 stall_cnt_o  out  16  saturating count of cycles with stall_o[0]=1.

Function
REQ-018 The FSM SHALL have the states RUN and MC_WAIT.
REQ-019 Load-use hazard (combinational) SHALL be: ex_is_load_i & ex_wreg_i & ex_wd_i!=0 & ((id_reg1_read_i & addr1==ex_wd_i) | (id_reg2_read_i & addr2==ex_wd_i)).
REQ-020 In RUN, priority SHALL be: branch_flush_i > ex_mc_req_i > load-use > none.
REQ-021 RUN with branch_flush_i: flush_o=1, new_pc_o=branch_target_i, stall_o=0, in the same cycle.
REQ-022 RUN with ex_mc_req_i: mc_start_o=1 for one cycle, stall_o=6'b001111, and the next state SHALL be MC_WAIT.
REQ-023 RUN with load-use only: stall_o=6'b000111 for exactly that cycle, so the bubble enters EX; no state change.
REQ-024 RUN with no condition: stall_o=0, flush_o=0.
REQ-025 MC_WAIT without mc_done_i: stall_o=6'b001111; branch_flush_i and load-use SHALL be ignored.
REQ-026 MC_WAIT with mc_done_i: stall_o=0 in the same cycle, and the next state SHALL be RUN.
REQ-027 A 7-bit wait counter SHALL clear on MC_WAIT entry and increment each MC_WAIT cycle.
REQ-028 On reaching MC_TIMEOUT=64 without mc_done_i: mc_abort_o=1 for one cycle, stall_o=0, mc_err_o set, next state RUN.
REQ-029 mc_done_i and timeout in the same cycle SHALL resolve as done, with no abort and no error.
REQ-030 mc_done_i in RUN SHALL be ignored.
REQ-031 stall_cnt_o SHALL increment on every cycle with stall_o[0]=1 and saturate at 16'hFFFF.
REQ-032 Every output except the counters and mc_err_o SHALL be combinational from inputs and state; the FSM, counters and mc_err_o SHALL be registered.

Reset
REQ-033 On rst=0, asynchronously: state=RUN, wait counter=0, stall_cnt_o=0, mc_err_o=0.
REQ-034 While rst=0, stall_o, flush_o, new_pc_o, mc_start_o and mc_abort_o SHALL all be 0.
REQ-035 Reset asserted in MC_WAIT SHALL abandon the wait with no abort pulse.
REQ-036 The first cycle after reset release SHALL be RUN.

Structure
REQ-037 defines.v SHALL hold StallBus (5:0), the stall encodings StallNone/StallLoadUse/StallMc, MC_TIMEOUT and the state encodings.
REQ-038 The load-use comparison SHALL live in a combinational sub-module hazard_det, instantiated once.

Verification
REQ-039 The bench SHALL cover: load x5 in EX, ID reads rs1=x5 -> stall_o=000111 for one cycle, then 000000.
REQ-040 The bench SHALL cover: load x0 in EX, ID reads x0 -> no stall.
REQ-041 The bench SHALL cover: ex_mc_req_i=1, mc_done_i after 10 cycles -> mc_start_o one pulse, 001111 for 11 cycles, stall_cnt_o=11.
REQ-042 The bench SHALL cover: ex_mc_req_i with no done -> mc_abort_o at the 64th MC_WAIT cycle, mc_err_o=1, state RUN.
REQ-043 The bench SHALL cover: branch_flush_i with target 32'h80 plus ex_mc_req_i in the same cycle -> flush_o=1, new_pc_o=32'h80, no mc_start_o.
REQ-044 The bench SHALL cover: rst=0 during MC_WAIT -> all outputs 0 immediately, RUN after release.
